// File: rtl/mcb_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcb_resp_pkg
//  Description : Shared definitions for the BRAM-backed MCB user-port
//                responder: instruction codes, command record, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package mcb_resp_pkg;

    // MCB user-port instruction codes
    localparam logic [2:0] INSTR_WR      = 3'b000;
    localparam logic [2:0] INSTR_RD      = 3'b001;
    localparam logic [2:0] INSTR_WR_AP   = 3'b010;
    localparam logic [2:0] INSTR_RD_AP   = 3'b011;
    localparam logic [2:0] INSTR_REFRESH = 3'b100;

    // One queued command as it sits in the command FIFO
    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] byte_addr;
    } cmd_rec_t;

    localparam int CMD_REC_W = $bits(cmd_rec_t);   // 3 + 6 + 30 = 39

    // Command execution state machine
    typedef enum logic [2:0] {
        ST_CALIB   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_READ    = 3'd5
    } resp_state_t;

endpackage : mcb_resp_pkg
`default_nettype wire

// File: rtl/mcb_port_responder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fwft_fifo
//  Description : Single-clock first-word-fall-through FIFO with full, empty
//                and occupancy outputs. Pushes while full and pops while
//                empty are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fwft_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_push_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_head,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;
    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array: contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule : sync_fwft_fifo
`default_nettype wire

// File: rtl/mcb_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mcb_port_responder
//  Description : BRAM-backed stand-in for one MIG/MCB user port. Queues
//                commands and write data, executes bursts against internal
//                memory and returns read data in command order.
//  Revision    : 1.0  initial release
// ============================================================================
module mcb_port_responder
    import mcb_resp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int FIFO_DEPTH   = 64,
    parameter int CMD_DEPTH    = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic                                calib_done,
    input  logic                                cmd_en,
    input  logic [2:0]                          cmd_instr,
    input  logic [5:0]                          cmd_bl,
    input  logic [29:0]                         cmd_byte_addr,
    output logic                                cmd_full,
    output logic                                cmd_empty,
    input  logic                                wr_en,
    input  logic [3:0]                          wr_mask,
    input  logic [31:0]                         wr_data,
    output logic                                wr_full,
    output logic                                wr_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     wr_count,
    output logic                                wr_error,
    input  logic                                rd_en,
    output logic [31:0]                         rd_data,
    output logic                                rd_empty,
    output logic                                rd_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     rd_count,
    output logic                                rd_error,
    output logic                                cmd_error
);

    localparam int c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int c_CMD_CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int c_CAL_W     = $clog2(CALIB_CYCLES + 1);
    localparam logic [c_CAL_W-1:0] c_CAL_LAST   = c_CAL_W'(CALIB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FIFO_DEPTH = c_CNT_W'(FIFO_DEPTH);

    resp_state_t              r_state;
    resp_state_t              w_state_next;
    logic [c_CAL_W-1:0]       r_calib_cnt;
    logic [5:0]               r_bl;
    logic [5:0]               r_beat;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_bram_valid;
    logic [31:0]              r_bram_q;
    logic [31:0]              r_mem [2**ADDR_WIDTH];
    logic                     r_cmd_error;
    logic                     r_wr_error;
    logic                     r_rd_error;

    cmd_rec_t                 w_cmd_in;
    cmd_rec_t                 w_cmd_head;
    logic                     w_cmd_fifo_full;
    logic [c_CMD_CNT_W-1:0]   w_cmd_count;
    logic                     w_wr_fifo_full;
    logic [35:0]              w_wr_head;
    logic [31:0]              w_rd_head;

    logic                     w_cmd_pop;
    logic                     w_wr_pop;
    logic                     w_latch;
    logic                     w_illegal;
    logic                     w_mem_we;
    logic                     w_mem_rd;
    logic                     w_beat_last;
    logic [c_CNT_W-1:0]       w_need;
    logic [c_CNT_W-1:0]       w_rd_space;
    logic [3:0]               w_byte_we;

    // ------------------------------------------------------------------
    // Flags and status
    // ------------------------------------------------------------------
    assign calib_done = (r_state != ST_CALIB);
    assign cmd_full   = w_cmd_fifo_full | ~calib_done;
    assign wr_full    = w_wr_fifo_full  | ~calib_done;
    assign rd_data    = rd_empty ? 32'h0 : w_rd_head;
    assign cmd_error  = r_cmd_error;
    assign wr_error   = r_wr_error;
    assign rd_error   = r_rd_error;

    assign w_cmd_in    = '{instr: cmd_instr, bl: cmd_bl, byte_addr: cmd_byte_addr};
    assign w_need      = c_CNT_W'(r_bl) + c_CNT_W'(1);
    assign w_rd_space  = c_FIFO_DEPTH - rd_count;
    assign w_beat_last = (r_beat == r_bl);

    // Byte lanes are written only when unmasked; reset aborts an in-flight write
    assign w_byte_we = {4{w_mem_we & ~reset}} & ~w_wr_head[35:32];

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    sync_fwft_fifo #(.WIDTH(CMD_REC_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (cmd_en & ~cmd_full),
        .i_push_data (w_cmd_in),
        .i_pop       (w_cmd_pop),
        .o_head      (w_cmd_head),
        .o_full      (w_cmd_fifo_full),
        .o_empty     (cmd_empty),
        .o_count     (w_cmd_count)
    );

    sync_fwft_fifo #(.WIDTH(36), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (wr_en & ~wr_full),
        .i_push_data ({wr_mask, wr_data}),
        .i_pop       (w_wr_pop),
        .o_head      (w_wr_head),
        .o_full      (w_wr_fifo_full),
        .o_empty     (wr_empty),
        .o_count     (wr_count)
    );

    sync_fwft_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (r_bram_valid),
        .i_push_data (r_bram_q),
        .i_pop       (rd_en),
        .o_head      (w_rd_head),
        .o_full      (rd_full),
        .o_empty     (rd_empty),
        .o_count     (rd_count)
    );

    // ------------------------------------------------------------------
    // Command execution FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CALIB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_cmd_pop    = 1'b0;
        w_wr_pop     = 1'b0;
        w_latch      = 1'b0;
        w_illegal    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_rd     = 1'b0;
        case (r_state)
            ST_CALIB: begin
                if (r_calib_cnt == c_CAL_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_cmd_count != '0) begin
                    w_cmd_pop = 1'b1;
                    w_latch   = 1'b1;
                    case (w_cmd_head.instr)
                        INSTR_WR, INSTR_WR_AP: w_state_next = ST_WR_WAIT;
                        INSTR_RD, INSTR_RD_AP: w_state_next = ST_RD_WAIT;
                        INSTR_REFRESH:         w_state_next = ST_IDLE;
                        default:               w_illegal    = 1'b1;
                    endcase
                end
            end
            ST_WR_WAIT: begin
                // Start only once the whole burst is buffered so WRITE never stalls
                if (wr_count >= w_need) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wr_pop = 1'b1;
                w_mem_we = 1'b1;
                if (w_beat_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // Reserve room for the whole burst so the read FIFO cannot overflow
                if (w_rd_space >= w_need) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_mem_rd = 1'b1;
                if (w_beat_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Calibration counter, burst address/beat tracking and sticky errors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_calib_cnt  <= '0;
            r_bl         <= '0;
            r_beat       <= '0;
            r_addr       <= '0;
            r_bram_valid <= 1'b0;
            r_cmd_error  <= 1'b0;
            r_wr_error   <= 1'b0;
            r_rd_error   <= 1'b0;
        end else begin
            if (r_state == ST_CALIB) begin
                r_calib_cnt <= r_calib_cnt + c_CAL_W'(1);
            end
            if (w_latch) begin
                r_bl   <= w_cmd_head.bl;
                // Byte address to word address; bits above the memory are dropped
                r_addr <= ADDR_WIDTH'(w_cmd_head.byte_addr >> 2);
                r_beat <= '0;
            end else if (w_mem_we || w_mem_rd) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_beat <= r_beat + 6'd1;
            end
            r_bram_valid <= w_mem_rd;
            if ((cmd_en && cmd_full) || w_illegal) begin
                r_cmd_error <= 1'b1;
            end
            if (wr_en && wr_full) begin
                r_wr_error <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                r_rd_error <= 1'b1;
            end
        end
    end

    // Single-port BRAM with byte enables and registered read output
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_byte_we[b]) begin
                r_mem[r_addr][8*b +: 8] <= w_wr_head[8*b +: 8];
            end
        end
        if (w_mem_rd) begin
            r_bram_q <= r_mem[r_addr];
        end
    end

endmodule : mcb_port_responder
`default_nettype wire

// File: tb/tb_mcb_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcb_port_responder
//  Description : Scoreboard bench for mcb_port_responder. A word-array model
//                of memory predicts each read burst; a monitor pops the read
//                FIFO and compares against the predicted queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcb_port_responder;
    import mcb_resp_pkg::*;

    localparam int MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full, cmd_empty;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full, wr_empty, wr_error;
    logic [6:0]  wr_count;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty, rd_full, rd_error;
    logic [6:0]  rd_count;
    logic        cmd_error;

    always #5 clk = ~clk;

    mcb_port_responder #(
        .ADDR_WIDTH(12), .FIFO_DEPTH(64), .CMD_DEPTH(4), .CALIB_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .cmd_empty(cmd_empty),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
        .wr_empty(wr_empty), .wr_count(wr_count), .wr_error(wr_error),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_full(rd_full),
        .rd_count(rd_count), .rd_error(rd_error), .cmd_error(cmd_error)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;     // which bytes of d are known
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [31:0] mdata  [MEM_WORDS];
    logic [3:0]  mknown [MEM_WORDS];
    logic [31:0] wbuf [64];
    logic [3:0]  mbuf [64];
    bit          drain_en      = 1'b1;
    int          pop_budget    = 0;
    bit          pop_empty_req = 1'b0;
    int          max_rd_count  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int word_of(input logic [29:0] baddr);
        return int'(baddr >> 2) % MEM_WORDS;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t        e;
        logic [31:0] m32;
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (int'(rd_count) > max_rd_count) max_rd_count = int'(rd_count);
            if (!reset && !rd_empty && (drain_en || pop_budget > 0)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: actual=0x%0h required=no word", rd_data);
                end else begin
                    e   = exp_q.pop_front();
                    m32 = {{8{e.k[3]}}, {8{e.k[2]}}, {8{e.k[1]}}, {8{e.k[0]}}};
                    if (e.k != 4'h0) chk("rd_data", 64'(rd_data & m32), 64'(e.d & m32));
                end
                if (pop_budget > 0) pop_budget--;
                rd_en = 1'b1;
            end else if (!reset && pop_empty_req && rd_empty) begin
                rd_en         = 1'b1;
                pop_empty_req = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic issue_cmd(input logic [2:0] instr, input int bl, input logic [29:0] baddr);
        int n = 0;
        while (cmd_full && n < 500) begin @(negedge clk); n++; end
        if (cmd_full) expire("cmd_slot");
        cmd_en = 1'b1; cmd_instr = instr; cmd_bl = 6'(bl); cmd_byte_addr = baddr;
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    task automatic push_words(input int bl);
        int n = 0;
        while ((int'(wr_count) + bl + 1 > 64) && n < 500) begin @(negedge clk); n++; end
        for (int i = 0; i <= bl; i++) begin
            wr_en = 1'b1; wr_data = wbuf[i]; wr_mask = mbuf[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic model_write(input logic [29:0] baddr, input int nwords);
        int a;
        for (int i = 0; i < nwords; i++) begin
            a = (word_of(baddr) + i) % MEM_WORDS;
            for (int b = 0; b < 4; b++) begin
                if (!mbuf[i][b]) begin
                    mdata[a][8*b +: 8] = wbuf[i][8*b +: 8];
                    mknown[a][b]       = 1'b1;
                end
            end
        end
    endtask

    task automatic do_write(input logic [29:0] baddr, input int bl);
        push_words(bl);
        issue_cmd(($urandom % 2 == 0) ? INSTR_WR : INSTR_WR_AP, bl, baddr);
        model_write(baddr, bl + 1);
    endtask

    task automatic do_read(input logic [29:0] baddr, input int bl);
        int a;
        for (int i = 0; i <= bl; i++) begin
            a = (word_of(baddr) + i) % MEM_WORDS;
            exp_q.push_back('{d: mdata[a], k: mknown[a]});
        end
        issue_cmd(($urandom % 2 == 0) ? INSTR_RD : INSTR_RD_AP, bl, baddr);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_empty || !wr_empty || !rd_empty) && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) expire(name);
        tick(4);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        logic [29:0] ba;
        for (int i = 0; i < MEM_WORDS; i++) begin mdata[i] = '0; mknown[i] = '0; end
        reset = 1'b1; cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
        wr_en = 1'b0; wr_mask = '0; wr_data = '0;

        // Reset state
        tick(3);
        chk("rst_calib_done", calib_done, 0); chk("rst_cmd_full", cmd_full, 1);
        chk("rst_wr_full", wr_full, 1);       chk("rst_cmd_empty", cmd_empty, 1);
        chk("rst_wr_empty", wr_empty, 1);     chk("rst_rd_empty", rd_empty, 1);
        chk("rst_rd_full", rd_full, 0);       chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);     chk("rst_rd_data", rd_data, 0);
        chk("rst_errors", {cmd_error, wr_error, rd_error}, 0);

        // Calibration: calib_done rises on the 16th edge after reset release
        reset = 1'b0;
        tick(15);
        chk("calib_early", calib_done, 0); chk("calib_early_cmd_full", cmd_full, 1);
        tick(1);
        chk("calib_done", calib_done, 1); chk("calib_cmd_full", cmd_full, 0);
        chk("calib_wr_full", wr_full, 0);

        // Basic write then read with first-word latency
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0A0_0001 + i; mbuf[i] = 4'h0; end
        push_words(3);
        issue_cmd(INSTR_WR, 3, 30'h40);
        model_write(30'h40, 4);
        wait_drain("basic_write");
        do_read(30'h40, 3);
        tick(3);
        chk("rd_latency_early", rd_empty, 1);
        tick(1);
        chk("rd_latency_first", rd_empty, 0);
        chk("rd_first_word", rd_data, mdata[16]);
        wait_drain("basic_read");

        // Byte mask: bytes 0 and 2 keep their old value
        wbuf[0] = 32'hFFFF_FFFF; mbuf[0] = 4'h0; do_write(30'h0, 0);
        wbuf[0] = 32'h1234_5678; mbuf[0] = 4'b0101; do_write(30'h0, 0);
        do_read(30'h0, 0);
        wait_drain("mask");

        // Write FIFO fill to 64, overflow push, then a max-length burst
        chk("wr_error_pre", wr_error, 0);
        for (int i = 0; i < 64; i++) begin wbuf[i] = 32'hC000_0000 + i; mbuf[i] = 4'h0; end
        push_words(63);
        chk("wr_count_full", wr_count, 64); chk("wr_full", wr_full, 1);
        wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; wr_mask = 4'h0;
        tick(1);
        wr_en = 1'b0;
        chk("wr_error", wr_error, 1); chk("wr_count_after_drop", wr_count, 64);
        issue_cmd(INSTR_WR, 63, 30'(1000 * 4));
        model_write(30'(1000 * 4), 64);
        wait_drain("bl64_write");

        // Read backpressure: 60 words parked, 8-word burst must wait for room
        drain_en = 1'b0;
        do_read(30'(1000 * 4), 29);
        do_read(30'(1030 * 4), 29);
        n = 0;
        while (rd_count != 7'd60 && n < 300) begin tick(1); n++; end
        chk("rd_count_60", rd_count, 60);
        do_read(30'(1000 * 4), 7);
        tick(20);
        chk("rd_wait_hold", rd_count, 60);
        pop_budget = 4;
        n = 0;
        while (rd_count != 7'd64 && n < 200) begin tick(1); n++; end
        chk("rd_count_64", rd_count, 64); chk("rd_full", rd_full, 1);
        drain_en = 1'b1;
        wait_drain("backpressure");
        chk("rd_count_max_le_64", 64'(max_rd_count > 64), 0);

        // Wrap at top of memory; stray low and high byte-address bits ignored
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; mbuf[i] = 4'h0; end
        do_write(30'h3FF8 | 30'h0010_0000 | 30'd2, 3);
        do_read(30'(4094 * 4), 3);
        do_read(30'h0, 1);
        wait_drain("wrap");

        // Refresh is a no-op
        issue_cmd(INSTR_REFRESH, 0, 30'h0);
        do_read(30'(4094 * 4), 3);
        wait_drain("refresh");
        chk("refresh_no_error", cmd_error, 0);

        // Illegal instruction sets cmd_error and does not stall the queue
        issue_cmd(3'b110, 0, 30'h0);
        tick(4);
        chk("cmd_error", cmd_error, 1);
        do_read(30'h0, 1);
        wait_drain("after_illegal");

        // Pop while empty
        chk("rd_error_pre", rd_error, 0);
        pop_empty_req = 1'b1;
        tick(3);
        chk("rd_error", rd_error, 1); chk("rd_count_after_bad_pop", rd_count, 0);

        // Randomised mixed traffic in a window straddling the wrap point
        for (int t = 0; t < 40; t++) begin
            int bl;
            int w;
            bl = $urandom_range(0, 15);
            w  = (4000 + $urandom_range(0, 200)) % MEM_WORDS;
            ba = 30'($urandom);
            ba[13:2] = 12'(w);
            if ($urandom % 2 == 0) begin
                for (int i = 0; i <= bl; i++) begin
                    wbuf[i] = $urandom;
                    mbuf[i] = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
                end
                do_write(ba, bl);
            end else begin
                do_read(ba, bl);
            end
        end
        wait_drain("random");

        // Reset during the third word of a 16-word write
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h5500_0000 + i; mbuf[i] = 4'h0; end
        do_write(30'(100 * 4), 15);
        wait_drain("pre_reset_fill");
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h6600_0000 + i; mbuf[i] = 4'h0; end
        push_words(15);
        issue_cmd(INSTR_WR, 15, 30'(100 * 4));
        n = 0;
        while (wr_count != 7'd14 && n < 100) begin tick(1); n++; end
        if (n >= 100) expire("third_word");
        reset = 1'b1;
        tick(1);
        chk("mid_rst_calib_done", calib_done, 0); chk("mid_rst_cmd_empty", cmd_empty, 1);
        chk("mid_rst_wr_empty", wr_empty, 1);     chk("mid_rst_rd_empty", rd_empty, 1);
        chk("mid_rst_wr_count", wr_count, 0);
        model_write(30'(100 * 4), 2);
        reset = 1'b0;
        n = 0;
        while (!calib_done && n < 100) begin tick(1); n++; end
        chk("recalib", calib_done, 1);
        do_read(30'(100 * 4), 15);
        wait_drain("post_reset_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mcb_port_responder
`default_nettype wire

// File: doc/mcb_port_responder.md
Name: mcb_port_responder

Overview:
- Single-clock, BRAM-backed responder for one MIG/MCB user port (command, write-data and read-data FIFO interface).
- Lets ddrPort0/ddrPort1-style initiators and the render/colour pipeline run in simulation, or on a board with DDR2 bypassed.
- Accepts write/read/refresh commands, executes bursts against internal memory, and returns read data in order.

Parameters:
- ADDR_WIDTH, 12, log2 of memory depth in 32-bit words (4096 words).
- FIFO_DEPTH, 64, depth of the write-data and read-data FIFOs in words; counts saturate at 64.
- CMD_DEPTH, 4, command FIFO depth.
- CALIB_CYCLES, 16, cycles after reset before calib_done asserts.

Ports:
- clk  in  1  single clock for all ports and memory.
- reset  in  1  synchronous, active-high.
- calib_done  out  1  responder ready.
- cmd_en  in  1  push command.
- cmd_instr  in  3  000 write, 001 read, 010 write-AP, 011 read-AP, 100 refresh.
- cmd_bl  in  6  burst length minus 1 (1..64 words).
- cmd_byte_addr  in  30  byte address.
- cmd_full  out  1  command FIFO full or not calibrated.
- cmd_empty  out  1  command FIFO empty.
- wr_en  in  1  push write word.
- wr_mask  in  4  byte mask; 1 = byte not written.
- wr_data  in  32  write word.
- wr_full  out  1  write FIFO full or not calibrated.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy.
- wr_error  out  1  sticky; push while full.
- rd_en  in  1  pop read word.
- rd_data  out  32  head of read FIFO (first-word fall-through).
- rd_empty  out  1  read FIFO empty.
- rd_full  out  1  read FIFO full.
- rd_count  out  7  read FIFO occupancy.
- rd_error  out  1  sticky; pop while empty.
- cmd_error  out  1  sticky; illegal instr or push while full.

Behaviour:
- Reset values:
  - calib_done=0, cmd_full=1, wr_full=1, cmd_empty=1, wr_empty=1, rd_empty=1, rd_full=0.
  - All counts 0, all error flags 0, rd_data=0.
  - FIFOs flushed, FSM in CALIB.
  - Memory contents are NOT cleared.
  - Reset mid-burst aborts the burst immediately; partially written words remain.
- Word address = cmd_byte_addr[ADDR_WIDTH+1:2]; byte-address bits [1:0] and bits above ADDR_WIDTH+1 are ignored.
  - Each burst word increments the address modulo 2^ADDR_WIDTH (wrap at top of memory).
- Push rules:
  - A push is accepted only when its enable is high and the matching full flag is low.
  - A rejected push is dropped and sets its sticky error flag.
  - A pop with rd_empty=1 is ignored and sets rd_error.
  - Push and pop in the same cycle leave the count unchanged.
- FSM:
  - CALIB: count CALIB_CYCLES, then set calib_done=1 and go to IDLE.
  - IDLE: if command FIFO non-empty, pop and latch instr/bl/addr.
    - write/write-AP -> WR_WAIT.
    - read/read-AP -> RD_WAIT.
    - refresh -> IDLE (one cycle, no-op).
    - Codes 101-111 -> IDLE and set cmd_error.
  - WR_WAIT: stay until wr_count >= bl+1 -> WRITE.
  - WRITE: pop one word per cycle; write unmasked bytes; bl+1 cycles -> IDLE.
  - RD_WAIT: stay until FIFO_DEPTH - rd_count >= bl+1 -> READ.
    - The read FIFO never overflows.
  - READ: issue one BRAM read per cycle for bl+1 cycles -> IDLE.
    - Data is pushed to the read FIFO one cycle after each address (registered BRAM output).
- Latency:
  - A read command pushed in cycle 0 to an idle responder with an empty read FIFO gives rd_empty=0 with the first word on rd_data in cycle 4.
  - Later words follow one per cycle.
- Ordering and hazards:
  - Commands execute strictly in order.
  - A read after a write to the same address returns the new data.
- Memory is inferred as a single-port BRAM, 32 bits wide, with 4 byte-write enables.

Decomposition:
- Package mcb_resp_pkg:
  - Instruction code constants (INSTR_WR, INSTR_RD, INSTR_WR_AP, INSTR_RD_AP, INSTR_REFRESH).
  - FSM state encoding.
  - Command record width (3+6+30 = 39).
- Sub-module sync_fwft_fifo (WIDTH, DEPTH), instantiated three times:
  - Command FIFO, 39 bits wide.
  - Write FIFO, 36 bits wide (mask plus data).
  - Read FIFO, 32 bits wide.
  - Provides full/empty/count.

Test Plan:
- Calibration: release reset -> calib_done rises exactly 16 cycles later; cmd_full and wr_full fall in the same cycle.
- Basic write then read:
  - Stimulus: push words 0xA0A0_0001..0xA0A0_0004 (mask 0), then write cmd addr 0x40 bl=3, then read cmd addr 0x40 bl=3.
  - Response: the 4 words return in order; first word visible 4 cycles after the read cmd_en once the write has retired.
- Byte mask: write 0xFFFF_FFFF to addr 0, then 0x1234_5678 with mask 4'b0101, then read -> 0x12FF_56FF.
- Backpressure:
  - Fill the read FIFO to 60 words without popping, then issue read bl=7 -> FSM holds in RD_WAIT.
  - Pop 4 words -> burst proceeds; rd_count never exceeds 64.
- Wrap, refresh and illegal codes:
  - Write bl=3 at word 4094 -> data lands in words 4094, 4095, 0, 1.
  - Refresh cmd -> no memory change.
  - instr=3'b110 -> cmd_error=1.
  - wr_en while wr_full -> wr_error=1.
- Reset mid-operation:
  - Assert reset during the 3rd word of a bl=15 write -> all FIFOs empty and calib_done=0 next cycle.
  - After recalibration, a read shows words 0-1 updated and words 2-15 unchanged.
